instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Reads instructions from instruction memory at the current PC and hands each (pc, instruction) pair to decode. It is the consumer of the PC stream.
- Owns PC sequencing:
  - sequential +4 stepping;
  - redirects from branch/jump resolution;
  - discarding stale in-flight responses.
- Sits between the instruction-memory port and the decode/execute stage. It uses valid/ready on both sides and allows one outstanding memory request.

Parameters:
- BASE_PC, 32'h0000_0000, fetch address after reset. Must be 4-byte aligned; a misaligned value is an elaboration-time $error.
- XLEN, 32, address/data width. Only 32 is supported.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  32  fetch address; always equals fetch_pc.
- imem_rsp_valid  in  1  response data valid. Pulses exactly once per accepted request, at least 1 cycle after acceptance.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  one-cycle redirect pulse from execute.
- redirect_pc  in  32  redirect target.
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode accepts the instruction.
- inst_pc  out  32  PC of the presented instruction.
- inst  out  32  presented instruction word.
- fetch_fault  out  1  sticky misaligned-redirect fault.
- fault_pc  out  32  offending redirect target.

Behaviour:
- Reset (rst high at a clk edge):
  - state=IDLE, fetch_pc=BASE_PC, drop_pending=0;
  - inst_valid=0, inst_pc=0, inst=0;
  - fetch_fault=0, fault_pc=0;
  - imem_req_valid=0 while in IDLE.
- Reset mid-operation:
  - abandons any held instruction or outstanding request;
  - a memory response arriving after reset while in IDLE or FETCH is ignored.
- States:
  - IDLE: moves to FETCH the first cycle rst is low. The first request is therefore visible 1 cycle after reset release.
  - FETCH: imem_req_valid=1, imem_req_addr=fetch_pc. On imem_req_ready, go to WAIT.
  - WAIT: on imem_rsp_valid, go to OUT, or back to FETCH if drop_pending.
  - OUT: inst_valid=1. On inst_ready, set fetch_pc=fetch_pc+4 and go to FETCH.
  - HALT: entered on a fault. Holds until reset; no requests, inst_valid=0.
- Response latency:
  - the response is captured in a register; inst_valid rises the cycle after imem_rsp_valid;
  - inst_pc and inst stay stable while inst_valid=1 and inst_ready=0.
- PC increment is modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0000_0000.
- Redirect handling (redirect_valid=1):
  - Aligned target (redirect_pc[1:0]==0): fetch_pc is set to redirect_pc next cycle.
  - In FETCH without acceptance that cycle: the next request uses the target.
  - In FETCH with imem_req_ready that same cycle: the old request is in flight. Set drop_pending=1, go to WAIT.
  - In WAIT: set drop_pending=1. The next response is discarded, drop_pending clears, then go to FETCH at the target.
  - In OUT without inst_ready: the held instruction is dropped (inst_valid=0 next cycle). Go to FETCH.
  - In OUT with inst_ready the same cycle: the handshake completes (instruction delivered). fetch_pc takes the target, not +4.
  - Misaligned target: fetch_fault=1 and fault_pc=redirect_pc next cycle. Any held instruction is dropped; go to HALT.
    - If a request is outstanding, its response is ignored.
- Redirect during IDLE or HALT is ignored.
- imem_req_valid never deasserts in FETCH without acceptance or a redirect. imem_req_addr is stable while valid and not ready.
- Simultaneous imem_rsp_valid and redirect in WAIT: the response is discarded, and the next state is FETCH at the target.

Test Plan:
- Reset then streaming: BASE_PC=0, memory ready=1, response 1 cycle later, inst_ready=1 → requests 0x0, 0x4, 0x8, 0xC in order; inst_pc matches; first request appears 1 cycle after rst falls.
- Backpressure: hold inst_ready=0 for 5 cycles with inst_valid=1 at pc 0x4 → inst_pc/inst stable; no new request; after release, next request is 0x8.
- Redirect while WAIT: request 0x8 outstanding, redirect_pc=0x100 → response for 0x8 never reaches inst_valid; next request address is 0x100.
- Redirect in same cycle as inst handshake at pc 0x10, target 0x40 → 0x10 delivered once; next request is 0x40, not 0x14.
- Wrap: redirect to 0xFFFF_FFFC, accept it → next request is 0x0000_0000.
- Misaligned redirect to 0x0000_0102 → fetch_fault=1 and fault_pc=0x102 next cycle; no further requests; rst pulse clears fault and fetch restarts at BASE_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the fetch PC and keeps at most one instruction-memory
// request outstanding. It hands each (pc, instruction) pair to decode over valid/ready.
//
// state | meaning
// IDLE  | just out of reset; the first request goes out on the next cycle
// FETCH | request for fetch_pc presented to instruction memory
// WAIT  | request accepted, waiting for its single response
// OUT   | instruction captured and presented to decode
// HALT  | misaligned redirect seen; frozen until reset
module instr_fetch_unit #(
  parameter logic [31:0] BASE_PC = 32'h0000_0000,
  parameter int          XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic            o_imem_req_valid,
  input  logic            i_imem_req_ready,
  output logic [XLEN-1:0] o_imem_req_addr,
  input  logic            i_imem_rsp_valid,
  input  logic [XLEN-1:0] i_imem_rsp_data,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_inst_valid,
  input  logic            i_inst_ready,
  output logic [XLEN-1:0] o_inst_pc,
  output logic [XLEN-1:0] o_inst,
  output logic            o_fetch_fault,
  output logic [XLEN-1:0] o_fault_pc
);

  if (BASE_PC[1:0] != 2'b00) begin : g_base_pc_check
    $error("instr_fetch_unit: BASE_PC must be 4-byte aligned");
  end

  if (XLEN != 32) begin : g_xlen_check
    $error("instr_fetch_unit: only XLEN=32 is supported");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_OUT   = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [XLEN-1:0]   r_fetch_pc;
  logic              r_drop_pending;
  logic [XLEN-1:0]   r_inst_pc;
  logic [XLEN-1:0]   r_inst;
  logic              r_fetch_fault;
  logic [XLEN-1:0]   r_fault_pc;

  logic w_redir_live;
  logic w_redir_go;
  logic w_redir_bad;
  logic w_req_acc;
  logic w_rsp_in;
  logic w_inst_hs;
  logic w_capture;

  // Redirects only matter while the fetch pipeline is active.
  assign w_redir_live = i_redirect_valid &&
                        (r_state == S_FETCH || r_state == S_WAIT || r_state == S_OUT);
  assign w_redir_go   = w_redir_live && (i_redirect_pc[1:0] == 2'b00);
  assign w_redir_bad  = w_redir_live && (i_redirect_pc[1:0] != 2'b00);
  assign w_req_acc    = (r_state == S_FETCH) && i_imem_req_ready;
  assign w_rsp_in     = (r_state == S_WAIT) && i_imem_rsp_valid;
  assign w_inst_hs    = (r_state == S_OUT) && i_inst_ready;
  // A response is kept only if it was not already marked stale and no redirect
  // arrives alongside it.
  assign w_capture    = w_rsp_in && !r_drop_pending && !w_redir_live;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state selection; a misaligned redirect wins over everything else.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = S_FETCH;
      S_FETCH: begin
        if (w_redir_bad)           w_state_nxt = S_HALT;
        else if (i_imem_req_ready) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (w_redir_bad)           w_state_nxt = S_HALT;
        else if (i_imem_rsp_valid) w_state_nxt = w_capture ? S_OUT : S_FETCH;
      end
      S_OUT: begin
        if (w_redir_bad)                     w_state_nxt = S_HALT;
        else if (w_redir_go || i_inst_ready) w_state_nxt = S_FETCH;
      end
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    o_imem_req_valid = 1'b0;
    o_inst_valid     = 1'b0;
    case (r_state)
      S_FETCH: o_imem_req_valid = 1'b1;
      S_OUT:   o_inst_valid     = 1'b1;
      default: begin
        o_imem_req_valid = 1'b0;
        o_inst_valid     = 1'b0;
      end
    endcase
  end

  // Fetch PC sequencing and the stale-response marker.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc     <= BASE_PC;
      r_drop_pending <= 1'b0;
    end else begin
      if (w_redir_go) begin
        r_fetch_pc <= i_redirect_pc;
      end else if (w_inst_hs) begin
        r_fetch_pc <= r_fetch_pc + XLEN'(4);
      end
      // The request accepted in a redirect cycle is already in flight, so its
      // response must be thrown away when it returns.
      if (w_rsp_in || w_redir_bad) begin
        r_drop_pending <= 1'b0;
      end else if (w_redir_go && (w_req_acc || r_state == S_WAIT)) begin
        r_drop_pending <= 1'b1;
      end
    end
  end

  // Capture the returned instruction together with the PC it was fetched from.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inst_pc <= '0;
      r_inst    <= '0;
    end else if (w_capture) begin
      r_inst_pc <= r_fetch_pc;
      r_inst    <= i_imem_rsp_data;
    end
  end

  // Sticky fault record for a misaligned redirect target.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_fault <= 1'b0;
      r_fault_pc    <= '0;
    end else if (w_redir_bad) begin
      r_fetch_fault <= 1'b1;
      r_fault_pc    <= i_redirect_pc;
    end
  end

  assign o_imem_req_addr = r_fetch_pc;
  assign o_inst_pc       = r_inst_pc;
  assign o_inst          = r_inst;
  assign o_fetch_fault   = r_fetch_fault;
  assign o_fault_pc      = r_fault_pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit. A transaction-level model tracks the
// architectural "next PC to deliver" and the set of in-flight fetches, and
// marks any fetch overtaken by a redirect as stale.
module tb_instr_fetch_unit;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          NCYC = 20000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_pc;
  logic [31:0] inst;
  logic        fetch_fault;
  logic [31:0] fault_pc;

  instr_fetch_unit #(.BASE_PC(BASE), .XLEN(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .o_imem_req_valid (imem_req_valid),
    .i_imem_req_ready (imem_req_ready),
    .o_imem_req_addr  (imem_req_addr),
    .i_imem_rsp_valid (imem_rsp_valid),
    .i_imem_rsp_data  (imem_rsp_data),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .o_inst_valid     (inst_valid),
    .i_inst_ready     (inst_ready),
    .o_inst_pc        (inst_pc),
    .o_inst           (inst),
    .o_fetch_fault    (fetch_fault),
    .o_fault_pc       (fault_pc)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory contents: an invertible scramble so every address has a unique word.
  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  typedef struct {
    logic [31:0] addr;
    bit          stale;
    int          due;
  } pend_t;

  pend_t       q[$];
  pend_t       ent;
  bit          m_known = 0;
  bit          m_idle;
  bit          m_first;
  bit          m_halt;
  logic [31:0] m_pc;
  logic [31:0] m_fpc;
  int          m_exp;
  logic [31:0] m_exp_pc;
  bit          m_hold;
  logic [31:0] m_hold_pc;
  logic [31:0] m_hold_inst;
  int          halt_cnt;
  int          n_deliv = 0;

  initial begin
    logic [31:0] tmp;
    int          r;
    bit          got_rsp;
    bit          hs;
    bit          acc;
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      // ---- check outputs against the expectations formed last cycle ----
      if (m_known) begin
        if (m_idle) begin
          chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
          chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
          chk("rst_inst_pc", inst_pc, 32'd0);
          chk("rst_inst", inst, 32'd0);
          chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
          chk("rst_fault_pc", fault_pc, 32'd0);
        end else begin
          chk("fault_flag", {31'b0, fetch_fault}, {31'b0, m_halt});
          if (m_halt) begin
            chk("fault_pc", fault_pc, m_fpc);
            chk("halt_no_req", {31'b0, imem_req_valid}, 32'd0);
            chk("halt_no_inst", {31'b0, inst_valid}, 32'd0);
          end
          if (m_first) begin
            chk("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
            chk("first_req_addr", imem_req_addr, BASE);
          end
          if (m_exp == 1) begin
            chk("rsp_to_valid", {31'b0, inst_valid}, 32'd1);
            chk("rsp_pc", inst_pc, m_exp_pc);
            chk("rsp_inst", inst, memfn(m_exp_pc));
          end else if (m_exp == 2) begin
            chk("valid_dropped", {31'b0, inst_valid}, 32'd0);
          end
          if (m_hold) begin
            chk("hold_valid", {31'b0, inst_valid}, 32'd1);
            chk("hold_pc", inst_pc, m_hold_pc);
            chk("hold_inst", inst, m_hold_inst);
          end
        end
      end

      // ---- drive this cycle's inputs ----
      rst = (cyc < 3) || (m_halt && halt_cnt >= 8) || ($urandom_range(0, 299) == 0);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      inst_ready     = ($urandom_range(0, 2) != 0);
      if (q.size() > 0 && q[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = memfn(q[0].addr);
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
      end
      r = $urandom_range(0, 99);
      redirect_valid = 1'b0;
      redirect_pc    = $urandom;
      if (r < 8) begin
        redirect_valid = 1'b1;
        redirect_pc    = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
      end else if (r == 8) begin
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
      end else if (r == 9 && $urandom_range(0, 3) == 0) begin
        tmp            = $urandom;
        tmp[1:0]       = 2'($urandom_range(1, 3));
        redirect_valid = 1'b1;
        redirect_pc    = tmp;
      end

      // ---- advance the reference model across the coming edge ----
      if (rst) begin
        m_known  = 1;
        m_idle   = 1;
        m_first  = 0;
        m_halt   = 0;
        m_pc     = BASE;
        m_fpc    = '0;
        m_exp    = 0;
        m_hold   = 0;
        halt_cnt = 0;
        q.delete();
      end else if (m_idle) begin
        m_idle  = 0;
        m_first = 1;
        m_exp   = 0;
        m_hold  = 0;
      end else begin
        m_first = 0;
        got_rsp = imem_rsp_valid;
        if (got_rsp) ent = q.pop_front();
        m_exp  = 0;
        m_hold = 0;
        if (m_halt) begin
          halt_cnt++;
        end else begin
          hs  = inst_valid && inst_ready;
          acc = imem_req_valid && imem_req_ready;
          if (acc) begin
            chk("single_outstanding", 32'(q.size()), 32'd0);
            chk("req_addr", imem_req_addr, m_pc);
            q.push_back('{addr: m_pc, stale: 1'b0, due: cyc + $urandom_range(1, 3)});
          end
          if (hs) begin
            chk("deliver_pc", inst_pc, m_pc);
            chk("deliver_inst", inst, memfn(m_pc));
            n_deliv++;
          end
          if (redirect_valid) begin
            foreach (q[i]) q[i].stale = 1'b1;
            ent.stale = 1'b1;
            if (redirect_pc[1:0] == 2'b00) begin
              m_pc = redirect_pc;
            end else begin
              m_halt = 1;
              m_fpc  = redirect_pc;
            end
          end else if (hs) begin
            m_pc = m_pc + 32'd4;
          end
          if (!m_halt) begin
            if (got_rsp) begin
              m_exp    = ent.stale ? 2 : 1;
              m_exp_pc = ent.addr;
            end else if (inst_valid) begin
              if (inst_ready || redirect_valid) begin
                m_exp = 2;
              end else begin
                m_hold      = 1;
                m_hold_pc   = inst_pc;
                m_hold_inst = inst;
              end
            end
          end
        end
      end
    end

    chk("progress", {31'b0, (n_deliv >= 500)}, 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
